// File: rtl/token_emitter.sv
// -----------------------------------------------------------------------------
// token_emitter
//   Downstream stage of the encoder's vocabulary matcher. Each accepted match
//   result becomes one token id in a small output FIFO: a hit pushes its
//   vocabulary id, a miss pushes UNK_ID. The start address of the next match
//   attempt is tracked here and fed back to the matcher. When the matcher
//   reports the input is exhausted, an EOS_ID entry flagged "last" is appended.
//   Once that entry has drained, done is raised until cs drops.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both 1. A producer holds valid and its payload stable
//   until that transfer. match_ready depends only on registered state, the
//   FIFO fill level and cs. It never depends on tok_ready combinationally.
//
// Ports
//   clk, rst_n       clock; synchronous active-low reset
//   cs               chip select; dropping it idles/aborts the block
//   match_*          result channel from the matcher (valid/ready)
//   match_done       matcher has exhausted the input (sampled in RUN)
//   in_offset        start address of the next match attempt
//   tok_*            token stream out (valid/ready), tok_last marks EOS
//   unk_count        saturating count of UNK tokens emitted
//   overflow         sticky flag: in_offset would have exceeded its maximum
//   done             EOS has been consumed; held until cs=0
//   state_dbg        current FSM state, for checkers
// -----------------------------------------------------------------------------
module token_emitter #(
    parameter int          ADDR_WIDTH  = 4,
    parameter int          TOKEN_WIDTH = 8,
    parameter int          FIFO_DEPTH  = 4,
    parameter int unsigned UNK_ID      = 0,
    parameter int unsigned EOS_ID      = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic                   match_valid,
    output logic                   match_ready,
    input  logic                   match_found,
    input  logic [TOKEN_WIDTH-1:0] match_token_id,
    input  logic [ADDR_WIDTH-1:0]  match_len,
    input  logic                   match_done,
    output logic [ADDR_WIDTH-1:0]  in_offset,
    output logic                   tok_valid,
    input  logic                   tok_ready,
    output logic [TOKEN_WIDTH-1:0] tok_data,
    output logic                   tok_last,
    output logic [ADDR_WIDTH-1:0]  unk_count,
    output logic                   overflow,
    output logic                   done,
    output logic [2:0]             state_dbg
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_EOS   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [2:0] state_q, state_d;

    // FIFO entry = {last, token id}
    logic [TOKEN_WIDTH:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;

    logic                 full, empty;
    logic                 accept, eos_push, push, pop, flush, enter_run;
    logic [TOKEN_WIDTH:0] push_data;
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH:0]   offset_sum;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);

    assign match_ready = (state_q == ST_RUN) && !full && cs;
    assign accept      = match_valid && match_ready;
    assign eos_push    = (state_q == ST_EOS) && !full && cs;
    assign push        = accept || eos_push;
    assign pop         = !empty && tok_ready;
    assign enter_run   = (state_q == ST_IDLE) && cs;

    // Any active state left via cs=0 discards whatever is still queued.
    assign flush = !cs && ((state_q == ST_RUN) || (state_q == ST_EOS) ||
                           (state_q == ST_DRAIN));

    assign push_data = eos_push ? {1'b1, TOKEN_WIDTH'(EOS_ID)}
                                : {1'b0, (match_found ? match_token_id
                                                      : TOKEN_WIDTH'(UNK_ID))};

    assign tok_valid = !empty;
    assign tok_data  = mem[rd_ptr][TOKEN_WIDTH-1:0];
    assign tok_last  = mem[rd_ptr][TOKEN_WIDTH];

    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

    // A miss, or a hit reporting zero length, still advances by one byte.
    always_comb begin
        inc = ADDR_WIDTH'(1);
        if (match_found && (match_len != '0)) begin
            inc = match_len;
        end
    end

    // One extra bit so the carry out signals that the address space is exceeded.
    assign offset_sum = {1'b0, in_offset} + {1'b0, inc};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs) state_d = ST_RUN;
            ST_RUN: begin
                if (!cs)              state_d = ST_IDLE;
                else if (accept)      state_d = ST_RUN;
                else if (match_done)  state_d = ST_EOS;
            end
            ST_EOS: begin
                if (!cs)              state_d = ST_IDLE;
                else if (eos_push)    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as soon as the last entry pops so done follows it directly.
                if (!cs)                                         state_d = ST_IDLE;
                else if (empty || ((count == CW'(1)) && pop))    state_d = ST_DONE;
            end
            ST_DONE:  if (!cs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_offset <= '0;
            unk_count <= '0;
            overflow  <= 1'b0;
        end else if (enter_run) begin
            in_offset <= '0;
            unk_count <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            if (offset_sum[ADDR_WIDTH]) begin
                in_offset <= '1;
                overflow  <= 1'b1;
            end else begin
                in_offset <= offset_sum[ADDR_WIDTH-1:0];
            end
            if (!match_found && (unk_count != '1)) begin
                unk_count <= unk_count + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_token_emitter.sv
// -----------------------------------------------------------------------------
// tb_token_emitter
//   Directed bench for token_emitter. Drivers push the expected token entry
//   ({last, id}) into exp_q at the moment a result is handed over. A separate
//   monitor pops exp_q on every token handshake and compares the two. Offsets,
//   counters and flags are checked inline against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_token_emitter;

    localparam int AW = 4;
    localparam int TW = 8;
    localparam logic [TW-1:0] UNK = 8'd0;
    localparam logic [TW-1:0] EOS = 8'd1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          match_valid;
    logic          match_ready;
    logic          match_found;
    logic [TW-1:0] match_token_id;
    logic [AW-1:0] match_len;
    logic          match_done;
    logic [AW-1:0] in_offset;
    logic          tok_valid;
    logic          tok_ready;
    logic [TW-1:0] tok_data;
    logic          tok_last;
    logic [AW-1:0] unk_count;
    logic          overflow;
    logic          done;
    logic [2:0]    state_dbg;

    logic [TW:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    token_emitter #(
        .ADDR_WIDTH (AW),
        .TOKEN_WIDTH(TW),
        .FIFO_DEPTH (4),
        .UNK_ID     (0),
        .EOS_ID     (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cs            (cs),
        .match_valid   (match_valid),
        .match_ready   (match_ready),
        .match_found   (match_found),
        .match_token_id(match_token_id),
        .match_len     (match_len),
        .match_done    (match_done),
        .in_offset     (in_offset),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_data      (tok_data),
        .tok_last      (tok_last),
        .unk_count     (unk_count),
        .overflow      (overflow),
        .done          (done),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic f, input logic [TW-1:0] id, input logic [AW-1:0] len);
        int n;
        match_valid    = 1'b1;
        match_found    = f;
        match_token_id = id;
        match_len      = len;
        n = 0;
        while (!match_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", 32'(match_ready), 32'd1);
        if (match_ready) exp_q.push_back({1'b0, (f ? id : UNK)});
        tick();
        match_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((tok_valid || exp_q.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(tok_valid), 32'd0);
    endtask

    // From any state: drop cs into IDLE, then re-enter RUN.
    task automatic restart();
        cs = 1'b0;
        tick();
        tick();
        cs = 1'b1;
        tick();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && tok_valid && tok_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tok_unexpected: got last=%0d data=%0d expected nothing",
                         tok_last, tok_data);
            end else begin
                logic [TW:0] e;
                e = exp_q.pop_front();
                if ({tok_last, tok_data} !== e) begin
                    miscompares++;
                    $display("FAIL tok_stream: got last=%0d data=%0d expected last=%0d data=%0d",
                             tok_last, tok_data, e[TW], e[TW-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0; cs = 1'b1; match_valid = 1'b1; match_found = 1'b1;
        match_token_id = 8'd7; match_len = 4'd2; match_done = 1'b0; tok_ready = 1'b0;

        // 1 reset with cs and match_valid asserted
        tick();
        tick();
        check("rst_in_offset",   32'(in_offset),   32'd0);
        check("rst_unk_count",   32'(unk_count),   32'd0);
        check("rst_overflow",    32'(overflow),    32'd0);
        check("rst_done",        32'(done),        32'd0);
        check("rst_match_ready", 32'(match_ready), 32'd0);
        check("rst_tok_valid",   32'(tok_valid),   32'd0);
        check("rst_tok_data",    32'(tok_data),    32'd0);
        check("rst_tok_last",    32'(tok_last),    32'd0);
        check("rst_state",       32'(state_dbg),   32'd0);
        match_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("run_state", 32'(state_dbg), 32'd1);

        // 2 hits
        tok_ready = 1'b1;
        send(1'b1, 8'd5, 4'd3);
        check("hit1_offset", 32'(in_offset), 32'd3);
        send(1'b1, 8'd9, 4'd2);
        check("hit2_offset", 32'(in_offset), 32'd5);
        wait_empty();
        check("hits_unk_count", 32'(unk_count), 32'd0);

        // 3 miss then EOS
        restart();
        check("restart_offset", 32'(in_offset), 32'd0);
        send(1'b0, 8'd77, 4'd0);
        check("miss_unk_count", 32'(unk_count), 32'd1);
        check("miss_offset",    32'(in_offset), 32'd1);
        match_done = 1'b1;
        exp_q.push_back({1'b1, EOS});
        tick();
        match_done = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("eos_done",       32'(done),       32'd1);
        check("eos_queue_used", 32'(exp_q.size()), 32'd0);
        tick();
        check("done_held", 32'(done), 32'd1);
        cs = 1'b0;
        tick();
        check("done_clear_idle", 32'(done), 32'd0);
        cs = 1'b1;
        tick();

        // 4 backpressure: five results offered into a four-entry FIFO
        tok_ready   = 1'b0;
        match_valid = 1'b1;
        match_found = 1'b1;
        match_len   = 4'd1;
        for (int i = 0; i < 4; i++) begin
            match_token_id = 8'(10 + i);
            check("bp_ready_room", 32'(match_ready), 32'd1);
            exp_q.push_back({1'b0, 8'(10 + i)});
            tick();
        end
        match_token_id = 8'd14;
        check("bp_ready_full", 32'(match_ready), 32'd0);
        tick();
        check("bp_fifth_held", 32'(match_ready), 32'd0);
        tok_ready = 1'b1;
        tick();
        tok_ready = 1'b0;
        check("bp_ready_after_pop", 32'(match_ready), 32'd1);
        exp_q.push_back({1'b0, 8'd14});
        tick();
        match_valid = 1'b0;
        check("bp_offset", 32'(in_offset), 32'd5);
        tok_ready = 1'b1;
        wait_empty();

        // 5 overflow
        restart();
        send(1'b1, 8'd30, 4'd7);
        send(1'b1, 8'd31, 4'd7);
        check("ovf_offset14",  32'(in_offset), 32'd14);
        check("ovf_not_yet",   32'(overflow),  32'd0);
        send(1'b1, 8'd32, 4'd3);
        check("ovf_offset_sat", 32'(in_offset), 32'd15);
        check("ovf_set",        32'(overflow),  32'd1);
        send(1'b0, 8'd0, 4'd0);
        check("ovf_sticky",      32'(overflow),  32'd1);
        check("ovf_offset_held", 32'(in_offset), 32'd15);
        wait_empty();
        restart();
        check("ovf_clear_on_run", 32'(overflow), 32'd0);

        // 6 abort with three entries queued
        tok_ready = 1'b0;
        send(1'b1, 8'd20, 4'd1);
        send(1'b1, 8'd21, 4'd1);
        send(1'b1, 8'd22, 4'd1);
        check("abort_queued", 32'(tok_valid), 32'd1);
        cs = 1'b0;
        tick();
        exp_q.delete();
        check("abort_tok_valid",   32'(tok_valid), 32'd0);
        check("abort_state_idle",  32'(state_dbg), 32'd0);
        check("abort_offset_kept", 32'(in_offset), 32'd3);
        cs = 1'b1;
        tick();
        check("abort_restart_offset", 32'(in_offset), 32'd0);
        check("abort_restart_state",  32'(state_dbg), 32'd1);
        tok_ready = 1'b1;
        send(1'b1, 8'd40, 4'd2);
        wait_empty();
        check("final_offset", 32'(in_offset), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
